fsm_stim_ctrl: RTL
==================

FSM_STIM_CTRL -- requirements
Module: fsm_stim_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_W, default 4, meaning the program address width (program depth = 2**DEPTH_W entries).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_b, input, 1, the reset; asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, run request, sampled only in IDLE.
REQ-005 The block SHALL have port len, input, DEPTH_W, step count, sampled with start; 0 means 2**DEPTH_W steps.
REQ-006 The block SHALL have ports wr_en (input, 1), wr_addr (input, DEPTH_W) and wr_data (input, 6), the program write port; wr_data = {A0,A4,I3,expU4,expU8,expO3}.
REQ-007 The block SHALL have ports A0, A4 and I3, each output, 1, stimulus to the controlled FSM.
REQ-008 The block SHALL have port fsm_rst_b, output, 1, active-low reset to the controlled FSM.
REQ-009 The block SHALL have ports U4, U8 and O3, each input, 1, Mealy outputs returned by the controlled FSM.
REQ-010 The block SHALL have ports busy, done and pass, each output, 1: run in progress; one-cycle completion pulse; no mismatch in the last run.
REQ-011 The block SHALL have port err_step, output, DEPTH_W, index of the first mismatching step.

Function
REQ-012 The controller SHALL have exactly four states: IDLE, FRST, RUN, DONE.
REQ-013 IDLE SHALL go to FRST on start=1, latching len, clearing the step counter, and setting pass=1 and err_step=0.
REQ-014 FRST SHALL last exactly one cycle, drive fsm_rst_b=0, then go to RUN.
REQ-015 fsm_rst_b SHALL be 1 in IDLE, RUN and DONE, and 0 in FRST and while rst_b=0.
REQ-016 In RUN step k, {A0,A4,I3} SHALL equal the stimulus bits of program[k] (asynchronous read); in all other states they SHALL be 0.
REQ-017 At each rising edge in RUN, {U4,U8,O3} SHALL be compared with the expected bits of program[k], and the step counter SHALL then increment.
REQ-018 On the first mismatch of a run, pass SHALL clear and err_step SHALL load k; later mismatches SHALL not change err_step.
REQ-019 RUN SHALL go to DONE after the edge that completes step len-1 (or step 2**DEPTH_W-1 when len=0); the counter SHALL not wrap mid-run.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-021 busy SHALL be 1 in FRST and RUN, else 0.
REQ-022 pass and err_step SHALL hold their values from DONE until the next accepted start.
REQ-023 Latency SHALL be: start edge to done pulse = steps+2 cycles.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 wr_en SHALL write program[wr_addr] only while busy=0; a write during busy SHALL be dropped.
REQ-026 A simultaneous wr_en and start in IDLE SHALL perform the write; the run SHALL use the updated entry.

Reset
REQ-027 rst_b=0 SHALL immediately force: state IDLE, step counter 0, busy 0, done 0, pass 0, err_step 0, A0/A4/I3 0, fsm_rst_b 0.
REQ-028 Program memory contents SHALL be unaffected by reset.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse; after release, the block SHALL wait in IDLE for a new start.

Structure
REQ-030 The state encodings (IDLE=0, FRST=1, RUN=2, DONE=3) and the wr_data field positions SHALL be defined in a shared package fsm_stim_pkg.
REQ-031 The program store SHALL be a separate sub-module stim_mem (2**DEPTH_W x 6, synchronous write, asynchronous read).
REQ-032 The controller state register SHALL be a plain always-block register (no d_ff instances).

Verification
REQ-033 Bench SHALL cover: program 3 entries matching the controlled FSM, len=3, start -> busy for 4 cycles, done on cycle 5 after start, pass=1, err_step=0.
REQ-034 Bench SHALL cover: the same program with entry 1 expected bits corrupted to 3'b111 -> pass=0, err_step=1.
REQ-035 Bench SHALL cover: entries 1 and 2 both corrupted -> err_step=1, not 2.
REQ-036 Bench SHALL cover: len=0 with DEPTH_W=4 -> 16 RUN cycles, done 18 cycles after start.
REQ-037 Bench SHALL cover: rst_b pulsed low during RUN step 2 -> outputs reset immediately, no done pulse, program intact on rerun.
REQ-038 Bench SHALL cover: start and wr_en pulsed while busy -> both ignored, and the run result is unchanged.

Source files
------------

// File: rtl/fsm_stim_pkg.sv
// Shared definitions for the FSM stimulus controller: controller state
// encoding and the field layout of one program entry.
package fsm_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FRST = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned PROG_W     = 6;
    localparam int unsigned BIT_A0     = 5;
    localparam int unsigned BIT_A4     = 4;
    localparam int unsigned BIT_I3     = 3;
    localparam int unsigned BIT_EXP_U4 = 2;
    localparam int unsigned BIT_EXP_U8 = 1;
    localparam int unsigned BIT_EXP_O3 = 0;

    function automatic logic [2:0] stim_bits(input logic [PROG_W-1:0] entry);
        return {entry[BIT_A0], entry[BIT_A4], entry[BIT_I3]};
    endfunction

    function automatic logic [2:0] exp_bits(input logic [PROG_W-1:0] entry);
        return {entry[BIT_EXP_U4], entry[BIT_EXP_U8], entry[BIT_EXP_O3]};
    endfunction

endpackage

// File: rtl/fsm_stim_ctrl_mem.sv
// Program store: synchronous write, asynchronous read, no reset so the
// program survives a controller reset.
module stim_mem #(
    parameter int unsigned DEPTH_W = 4,
    parameter int unsigned DATA_W  = 6
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [DEPTH_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic [DEPTH_W-1:0] raddr_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_W)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fsm_stim_ctrl.sv
// Replays a stored stimulus program into an external FSM, checks its Mealy
// outputs step by step and records pass/fail plus the first failing step.
module fsm_stim_ctrl
    import fsm_stim_pkg::*;
#(
    parameter int unsigned DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic [DEPTH_W-1:0] len,
    input  logic               wr_en,
    input  logic [DEPTH_W-1:0] wr_addr,
    input  logic [PROG_W-1:0]  wr_data,
    output logic               A0,
    output logic               A4,
    output logic               I3,
    output logic               fsm_rst_b,
    input  logic               U4,
    input  logic               U8,
    input  logic               O3,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [DEPTH_W-1:0] err_step
);

    state_e             state_q;
    logic [DEPTH_W-1:0] step_q;
    logic [DEPTH_W-1:0] len_q;
    logic               pass_q;
    logic [DEPTH_W-1:0] err_step_q;

    logic [PROG_W-1:0]  entry;
    logic [DEPTH_W-1:0] last_step_d;
    logic               mismatch_d;
    logic               mem_we;

    assign busy   = (state_q == FRST) || (state_q == RUN);
    assign done   = (state_q == DONE);
    assign mem_we = wr_en && !busy;

    stim_mem #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (PROG_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (step_q),
        .rdata_o (entry)
    );

    // len=0 wraps to all-ones, giving the full 2**DEPTH_W step run.
    assign last_step_d = len_q - DEPTH_W'(1);
    assign mismatch_d  = ({U4, U8, O3} != exp_bits(entry));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            step_q     <= '0;
            len_q      <= '0;
            pass_q     <= 1'b0;
            err_step_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FRST;
                        len_q      <= len;
                        step_q     <= '0;
                        pass_q     <= 1'b1;
                        err_step_q <= '0;
                    end
                end
                FRST: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (mismatch_d && pass_q) begin
                        pass_q     <= 1'b0;
                        err_step_q <= step_q;
                    end
                    if (step_q == last_step_d) begin
                        state_q <= DONE;
                    end else begin
                        step_q <= step_q + DEPTH_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {A0, A4, I3} = (state_q == RUN) ? stim_bits(entry) : '0;
    assign fsm_rst_b    = rst_b && (state_q != FRST);
    assign pass         = pass_q;
    assign err_step     = err_step_q;

endmodule
